// File: rtl/inert_intf.sv
// ---------------------------------------------------------------------------
// inert_intf
//   Command sequencer placed directly in front of a 16-bit SPI master.
//   After reset it waits INIT_CYCLES clocks for the sensor to power up. It
//   then writes four configuration registers. After that, each data-ready
//   interrupt triggers a read of pitch L/H and roll L/H. The four bytes are
//   assembled into signed 16-bit words and shown with a one-cycle vld strobe.
//
// Ports
//   clk      system clock
//   rst_n    asynchronous active-low reset
//   INT      sensor data-ready interrupt (asynchronous, active-high)
//   done     SPI master done: high when idle, low while busy
//   rd_data  SPI read word; only [7:0] carries register data
//   wrt      one-cycle pulse that starts an SPI transaction
//   cmd      SPI command word, valid while wrt is high and held afterwards
//   ptch     signed pitch rate {PH,PL}
//   roll     signed roll rate  {RH,RL}
//   vld      one-cycle strobe: ptch/roll were updated this cycle
// ---------------------------------------------------------------------------
module inert_intf #(
  parameter logic [15:0] INIT_CYCLES = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        INT,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic        wrt,
  output logic [15:0] cmd,
  output logic [15:0] ptch,
  output logic [15:0] roll,
  output logic        vld
);

  typedef enum logic [3:0] {
    INIT_WAIT,
    INIT1,
    INIT2,
    INIT3,
    INIT4,
    WAIT_INT,
    RD_PL,
    RD_PH,
    RD_RL,
    RD_RH,
    DONE_RD
  } state_t;

  state_t      state;
  logic [15:0] init_timer;

  // Stages 1 and 2 synchronize INT. Stage 3 holds the previous value so
  // that a rising edge can be detected.
  logic int_ff1, int_ff2, int_ff3;
  logic int_event;

  // done is high while the SPI master is idle. Only a low-to-high
  // transition means a transaction has completed.
  logic done_q;
  logic xfer_cmplt;

  logic [7:0] pl, ph, rl, rh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_ff1 <= 1'b0;
      int_ff2 <= 1'b0;
      int_ff3 <= 1'b0;
      done_q  <= 1'b1;
    end else begin
      int_ff1 <= INT;
      int_ff2 <= int_ff1;
      int_ff3 <= int_ff2;
      done_q  <= done;
    end
  end

  assign int_event  = int_ff2 & ~int_ff3;
  assign xfer_cmplt = done & ~done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= INIT_WAIT;
      init_timer <= 16'h0000;
      wrt        <= 1'b0;
      cmd        <= 16'h0000;
      ptch       <= 16'h0000;
      roll       <= 16'h0000;
      vld        <= 1'b0;
      pl         <= 8'h00;
      ph         <= 8'h00;
      rl         <= 8'h00;
      rh         <= 8'h00;
    end else begin
      // wrt and vld are single-cycle pulses unless a state re-asserts them.
      wrt <= 1'b0;
      vld <= 1'b0;
      case (state)
        INIT_WAIT: begin
          if (init_timer == INIT_CYCLES) begin
            wrt   <= 1'b1;
            cmd   <= 16'h0D02;
            state <= INIT1;
          end else begin
            init_timer <= init_timer + 16'd1;
          end
        end
        INIT1: if (xfer_cmplt) begin
          wrt   <= 1'b1;
          cmd   <= 16'h1053;
          state <= INIT2;
        end
        INIT2: if (xfer_cmplt) begin
          wrt   <= 1'b1;
          cmd   <= 16'h1150;
          state <= INIT3;
        end
        INIT3: if (xfer_cmplt) begin
          wrt   <= 1'b1;
          cmd   <= 16'h1460;
          state <= INIT4;
        end
        INIT4: if (xfer_cmplt) state <= WAIT_INT;
        // Interrupt edges are only noticed in this state. Edges seen
        // anywhere else are dropped on purpose and are not queued.
        WAIT_INT: if (int_event) begin
          wrt   <= 1'b1;
          cmd   <= 16'hA200;
          state <= RD_PL;
        end
        RD_PL: if (xfer_cmplt) begin
          pl    <= rd_data[7:0];
          wrt   <= 1'b1;
          cmd   <= 16'hA300;
          state <= RD_PH;
        end
        RD_PH: if (xfer_cmplt) begin
          ph    <= rd_data[7:0];
          wrt   <= 1'b1;
          cmd   <= 16'hA400;
          state <= RD_RL;
        end
        RD_RL: if (xfer_cmplt) begin
          rl    <= rd_data[7:0];
          wrt   <= 1'b1;
          cmd   <= 16'hA500;
          state <= RD_RH;
        end
        RD_RH: if (xfer_cmplt) begin
          rh    <= rd_data[7:0];
          state <= DONE_RD;
        end
        // The outputs change only here, so a partly finished read never
        // appears on ptch or roll.
        DONE_RD: begin
          ptch  <= {ph, pl};
          roll  <= {rh, rl};
          vld   <= 1'b1;
          state <= WAIT_INT;
        end
        default: state <= INIT_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_inert_intf.sv
module tb_inert_intf;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        int_in;
  logic        done;
  logic [15:0] rd_data;
  logic        wrt;
  logic [15:0] cmd;
  logic [15:0] ptch;
  logic [15:0] roll;
  logic        vld;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  inert_intf #(.INIT_CYCLES(16'd16)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .INT    (int_in),
    .done   (done),
    .rd_data(rd_data),
    .wrt    (wrt),
    .cmd    (cmd),
    .ptch   (ptch),
    .roll   (roll),
    .vld    (vld)
  );

  // Behavioural SPI master. Each transaction takes 40 cycles, and the
  // register byte is returned together with the rising edge of done.
  logic [7:0]  reg_pl, reg_ph, reg_rl, reg_rh;
  logic [15:0] cur_cmd;
  int          busy_cnt;
  int          overlap_err = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_cnt <= 0;
      done     <= 1'b1;
      rd_data  <= 16'h0000;
      cur_cmd  <= 16'h0000;
    end else if (wrt) begin
      if (busy_cnt != 0 || !done) overlap_err <= overlap_err + 1;
      busy_cnt <= 40;
      done     <= 1'b0;
      cur_cmd  <= cmd;
    end else if (busy_cnt > 1) begin
      busy_cnt <= busy_cnt - 1;
    end else if (busy_cnt == 1) begin
      busy_cnt <= 0;
      done     <= 1'b1;
      case (cur_cmd)
        16'hA200: rd_data <= {8'h00, reg_pl};
        16'hA300: rd_data <= {8'h00, reg_ph};
        16'hA400: rd_data <= {8'h00, reg_rl};
        16'hA500: rd_data <= {8'h00, reg_rh};
        default:  rd_data <= 16'h0000;
      endcase
    end
  end

  // Monitor: records every command pulse and every vld strobe.
  logic [15:0] cmd_log[$];
  int          wrt_cnt = 0;
  int          vld_cnt = 0;

  always @(negedge clk) begin
    if (rst_n && wrt) begin
      cmd_log.push_back(cmd);
      wrt_cnt <= wrt_cnt + 1;
    end
    if (rst_n && vld) vld_cnt <= vld_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_wrt_cnt(input string tag, input int target);
    int k;
    k = 0;
    while (wrt_cnt < target && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_timeout"}, 32'(wrt_cnt >= target), 32'd1);
  endtask

  task automatic wait_vld(input string tag);
    int k;
    k = 0;
    while (vld !== 1'b1 && k < 1000) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_vld_seen"}, 32'(vld), 32'd1);
  endtask

  task automatic pulse_int(input int n);
    int_in = 1'b1;
    cycles(n);
    int_in = 1'b0;
  endtask

  int lat;
  int base;

  initial begin
    rst_n  = 1'b0;
    int_in = 1'b0;
    reg_pl = 8'h00; reg_ph = 8'h00; reg_rl = 8'h00; reg_rh = 8'h00;
    cycles(3);
    check("rst_wrt",  32'(wrt),  32'd0);
    check("rst_cmd",  32'(cmd),  32'h0);
    check("rst_ptch", 32'(ptch), 32'h0);
    check("rst_roll", 32'(roll), 32'h0);
    check("rst_vld",  32'(vld),  32'd0);

    // Power-up delay, measured from the release of reset.
    rst_n = 1'b1;
    lat = 0;
    while (wrt !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("init_latency_ok", 32'(lat >= 16 && lat <= 17), 32'd1);
    check("init_cmd0", 32'(cmd), 32'h0D02);
    $display("init: first wrt %0d clk after release, cmd=%h", lat, cmd);

    // Pulse INT while the DUT is in INIT2; this edge must be dropped.
    wait_wrt_cnt("to_init2", 2);
    cycles(5);
    pulse_int(4);
    wait_wrt_cnt("init_done", 4);
    cycles(200);
    check("init_cmd1", 32'(cmd_log[1]), 32'h1053);
    check("init_cmd2", 32'(cmd_log[2]), 32'h1150);
    check("init_cmd3", 32'(cmd_log[3]), 32'h1460);
    check("init_wrt_cnt", 32'(wrt_cnt), 32'd4);
    check("init_no_vld", 32'(vld_cnt), 32'd0);
    check("init_no_overlap", 32'(overlap_err), 32'd0);
    $display("init: cmds %h %h %h %h", cmd_log[0], cmd_log[1], cmd_log[2], cmd_log[3]);

    // First read sequence.
    reg_pl = 8'h34; reg_ph = 8'h12; reg_rl = 8'hCD; reg_rh = 8'hAB;
    pulse_int(2);
    wait_vld("rd1");
    check("rd1_ptch", 32'(ptch), 32'h1234);
    check("rd1_roll", 32'(roll), 32'hABCD);
    cycles(1);
    check("rd1_vld_one_cycle", 32'(vld), 32'd0);
    check("rd1_cmd4", 32'(cmd_log[4]), 32'hA200);
    check("rd1_cmd5", 32'(cmd_log[5]), 32'hA300);
    check("rd1_cmd6", 32'(cmd_log[6]), 32'hA400);
    check("rd1_cmd7", 32'(cmd_log[7]), 32'hA500);
    $display("rd1: ptch=%h roll=%h", ptch, roll);

    // Hold INT high: only one read sequence may run.
    reg_pl = 8'h01; reg_ph = 8'h02; reg_rl = 8'h03; reg_rh = 8'h04;
    int_in = 1'b1;
    wait_vld("hold");
    cycles(300);
    check("hold_vld_cnt", 32'(vld_cnt), 32'd2);
    check("hold_wrt_cnt", 32'(wrt_cnt), 32'd12);
    check("hold_ptch", 32'(ptch), 32'h0201);
    int_in = 1'b0;
    cycles(5);
    int_in = 1'b1;
    wait_vld("rearm");
    int_in = 1'b0;
    cycles(300);
    check("rearm_vld_cnt", 32'(vld_cnt), 32'd3);
    check("rearm_wrt_cnt", 32'(wrt_cnt), 32'd16);
    $display("hold: vld_cnt=%0d wrt_cnt=%0d", vld_cnt, wrt_cnt);

    // Negative pitch value, with an INT pulse during RD_RL that must be ignored.
    reg_pl = 8'hFF; reg_ph = 8'h80; reg_rl = 8'h11; reg_rh = 8'h22;
    base = wrt_cnt;
    pulse_int(2);
    wait_wrt_cnt("to_rd_rl", base + 3);
    cycles(5);
    pulse_int(4);
    wait_vld("neg");
    check("neg_ptch", 32'(ptch), 32'h80FF);
    check("neg_roll", 32'(roll), 32'h2211);
    cycles(300);
    check("neg_wrt_cnt", 32'(wrt_cnt), 32'(base + 4));
    check("neg_vld_cnt", 32'(vld_cnt), 32'd4);
    check("no_overlap", 32'(overlap_err), 32'd0);
    $display("neg: ptch=%h roll=%h wrt_cnt=%0d", ptch, roll, wrt_cnt);

    // Assert reset while the DUT is in RD_PH.
    base = wrt_cnt;
    pulse_int(2);
    wait_wrt_cnt("to_rd_ph", base + 2);
    cycles(5);
    rst_n = 1'b0;
    #1;
    check("mid_rst_wrt",  32'(wrt),  32'd0);
    check("mid_rst_vld",  32'(vld),  32'd0);
    check("mid_rst_ptch", 32'(ptch), 32'h0);
    check("mid_rst_roll", 32'(roll), 32'h0);
    check("mid_rst_cmd",  32'(cmd),  32'h0);
    cycles(3);
    rst_n = 1'b1;
    lat = 0;
    while (wrt !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("reinit_latency_ok", 32'(lat >= 16 && lat <= 17), 32'd1);
    check("reinit_cmd0", 32'(cmd), 32'h0D02);
    $display("reinit: first wrt %0d clk after release, cmd=%h", lat, cmd);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/inert_intf.md
Name: inert_intf

Overview:
- Command sequencer that sits directly upstream of the 16-bit SPI master.
- After reset it waits for the sensor's power-up time, then writes four configuration registers.
- It then services each data-ready interrupt from the inertial sensor by reading four 8-bit registers (pitch L/H, roll L/H) over SPI.
- It assembles the bytes into signed 16-bit pitch and roll words and presents them with a one-cycle valid strobe.

Parameters:
- INIT_CYCLES, 16'hFFFF, number of clk cycles to wait after reset before the first SPI write.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- INT  input  1  sensor data-ready interrupt, asynchronous to clk, active-high
- done  input  1  SPI master done; high while idle, low during a transaction, re-asserted at completion
- rd_data  input  16  SPI master read word; only bits [7:0] carry register data
- wrt  output  1  one-cycle pulse that starts an SPI transaction
- cmd  output  16  SPI command word; must be stable on the cycle wrt is high
- ptch  output  16  signed pitch rate {PH,PL}
- roll  output  16  signed roll rate {RH,RL}
- vld  output  1  one-cycle strobe: ptch/roll updated this cycle

Behaviour:
- Reset (async) values: wrt=0, cmd=16'h0000, ptch=16'h0000, roll=16'h0000, vld=0. State=INIT_WAIT, init timer=0, INT synchronizer flops=0, done edge flop=1.
- INT input: passed through two flops for synchronization, then a third flop for edge detection. An INT event is synchronized INT rising (flop2=1, flop3=0). Latency: 3 clk from INT high to event.
- done input: "xfer_cmplt" is registered rising edge of done (done=1, done_q=0). The high-when-idle level of done is never treated as completion.
- Transaction rule: every SPI access is exactly one wrt pulse with cmd valid the same cycle. The FSM then waits for xfer_cmplt. At most one outstanding transaction at any time.
- Init timer: 16-bit counter, increments every clk in INIT_WAIT. On reaching INIT_CYCLES, issues first write. The timer is not used afterwards.
- States and transitions:
  - INIT_WAIT: timer==INIT_CYCLES -> wrt, cmd=16'h0D02 (enable INT), go INIT1.
  - INIT1: xfer_cmplt -> wrt, cmd=16'h1053 (accel cfg), go INIT2.
  - INIT2: xfer_cmplt -> wrt, cmd=16'h1150 (gyro cfg), go INIT3.
  - INIT3: xfer_cmplt -> wrt, cmd=16'h1460 (rounding on), go INIT4.
  - INIT4: xfer_cmplt -> go WAIT_INT.
  - WAIT_INT: INT event -> wrt, cmd=16'hA200 (read PL), go RD_PL.
  - RD_PL: xfer_cmplt -> latch PL=rd_data[7:0]; wrt, cmd=16'hA300, go RD_PH.
  - RD_PH: xfer_cmplt -> latch PH; wrt, cmd=16'hA400, go RD_RL.
  - RD_RL: xfer_cmplt -> latch RL; wrt, cmd=16'hA500, go RD_RH.
  - RD_RH: xfer_cmplt -> latch RH, go DONE_RD.
  - DONE_RD: ptch<={PH,PL}, roll<={RH,RL}, vld=1 for exactly this cycle, go WAIT_INT.
- Output update: ptch/roll change only in DONE_RD; partial reads never appear on the outputs.
- INT events while not in WAIT_INT are ignored (not queued). A new read sequence requires a fresh INT rising edge after returning to WAIT_INT.
- cmd holds its last value between wrt pulses.
- Byte latches PL/PH/RL/RH: 8-bit registers, reset to 0.
- Reset mid-operation (any state): all outputs and state return to reset values immediately. The init sequence restarts from INIT_WAIT with timer=0.
- No timeout: if done never rises, the FSM waits indefinitely in the current state.

Test Plan:
- Reset, INIT_CYCLES=16 (bench override), done model 40-cycle transaction -> wrt first high 16-17 clk after reset release with cmd=0D02; then 1053, 1150, 1460 in order, each wrt only after the prior done rise; no vld.
- After init, pulse INT; SPI model returns 8'h34, 8'h12, 8'hCD, 8'hAB -> cmds A200, A300, A400, A500 in order; vld one cycle with ptch=16'h1234, roll=16'hABCD.
- INT held high across the whole read sequence and after -> exactly one read sequence and one vld; second sequence only after INT low then high again.
- INT pulsed during INIT2 and again during RD_RL -> neither starts an extra sequence; wrt count equals 4 init + 4 per valid INT.
- Return 8'hFF, 8'h80 for pitch -> ptch=16'h80FF (negative value preserved, no sign manipulation); roll independently correct.
- Assert rst_n low during RD_PH -> wrt=0, vld=0, ptch/roll=0 at once; after release, init sequence restarts with 0D02 after INIT_CYCLES.
